// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer from dispatch to in-order memory drain
//
// Holds each store from allocation until it is drained to the data-memory port.
// Live entries run head..tail-1; the retired prefix runs head..ret-1 and drains
// in program order, one store per accepted memory request.
//
// Ports:
//   clk_i, reset_n_i              clock, synchronous active-low reset
//   alloc_v_i / alloc_sb_num_o    dispatch allocation request / granted index (tail)
//   sb_full_o, sb_empty_o         occupancy flags from registered count
//   wb_v_i, wb_sb_num_i,
//   wb_addr_i, wb_data_i          store writeback of address and data
//   rob_st_retire_i               oldest unretired store retires
//   flush_i                       discard all unretired entries
//   sb_wb_vector_o                per-entry allocated-and-written-back bits
//   sb_commit_pt_o                head pointer
//   mem_v_o, mem_addr_o,
//   mem_data_o, mem_ready_i       drain request for the head entry

package store_buffer_pkg;
    localparam int SB_ENTRY = 8;
    localparam int PW       = $clog2(SB_ENTRY);
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  alloc_v_i,
    output logic [PW-1:0]         alloc_sb_num_o,
    output logic                  sb_full_o,
    output logic                  sb_empty_o,
    input  logic                  wb_v_i,
    input  logic [PW-1:0]         wb_sb_num_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  rob_st_retire_i,
    input  logic                  flush_i,
    output logic [SB_ENTRY-1:0]   sb_wb_vector_o,
    output logic [PW-1:0]         sb_commit_pt_o,
    output logic                  mem_v_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_ready_i
);

    logic [PW-1:0]         head;
    logic [PW-1:0]         ret;
    logic [PW-1:0]         tail;
    logic [PW:0]           count;
    logic [PW:0]           ret_count;
    logic [SB_ENTRY-1:0]   wb;
    logic [ADDR_WIDTH-1:0] addr_q [SB_ENTRY];
    logic [DATA_WIDTH-1:0] data_q [SB_ENTRY];

    logic                  alloc_ok;
    logic                  drain;
    logic [PW-1:0]         head_nxt;
    logic [PW-1:0]         ret_nxt;
    logic [PW-1:0]         tail_nxt;
    logic [PW:0]           count_nxt;
    logic [PW:0]           ret_count_nxt;
    logic [SB_ENTRY-1:0]   wb_nxt;
    logic [PW-1:0]         rel_off [SB_ENTRY];
    logic [SB_ENTRY-1:0]   kept;

    assign sb_full_o      = (count == (PW+1)'(SB_ENTRY));
    assign sb_empty_o     = (count == '0);
    assign alloc_sb_num_o = tail;
    assign sb_commit_pt_o = head;
    assign sb_wb_vector_o = wb;
    assign mem_v_o        = (ret_count != '0);
    assign mem_addr_o     = addr_q[head];
    assign mem_data_o     = data_q[head];

    // A flush in the same cycle always wins over allocation.
    assign alloc_ok = alloc_v_i && !sb_full_o && !flush_i;
    assign drain    = mem_v_o && mem_ready_i;

    always_comb begin
        head_nxt      = head + PW'(drain);
        ret_nxt       = ret + PW'(rob_st_retire_i);
        ret_count_nxt = ret_count + (PW+1)'(rob_st_retire_i) - (PW+1)'(drain);
        if (flush_i) begin
            // Only the retired prefix survives, measured after this
            // cycle's retire and drain.
            tail_nxt  = ret_nxt;
            count_nxt = ret_count_nxt;
        end else begin
            tail_nxt  = tail + PW'(alloc_ok);
            count_nxt = count + (PW+1)'(alloc_ok) - (PW+1)'(drain);
        end
    end

    // An entry survives a flush when its distance from the new head lies
    // inside the new retired count.
    always_comb begin
        for (int i = 0; i < SB_ENTRY; i++) begin
            rel_off[i] = PW'(i) - head_nxt;
            kept[i]    = ({1'b0, rel_off[i]} < ret_count_nxt);
        end
    end

    // Later conditions override earlier ones, so a flush clears a bit even
    // if the same entry is written back in this cycle.
    always_comb begin
        wb_nxt = wb;
        for (int i = 0; i < SB_ENTRY; i++) begin
            if (wb_v_i && (wb_sb_num_i == PW'(i))) begin
                wb_nxt[i] = 1'b1;
            end
            if (alloc_ok && (tail == PW'(i))) begin
                wb_nxt[i] = 1'b0;
            end
            if (drain && (head == PW'(i))) begin
                wb_nxt[i] = 1'b0;
            end
            if (flush_i && !kept[i]) begin
                wb_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head      <= '0;
            ret       <= '0;
            tail      <= '0;
            count     <= '0;
            ret_count <= '0;
            wb        <= '0;
        end else begin
            head      <= head_nxt;
            ret       <= ret_nxt;
            tail      <= tail_nxt;
            count     <= count_nxt;
            ret_count <= ret_count_nxt;
            wb        <= wb_nxt;
        end
    end

    // Payload registers carry no reset; the wb bit qualifies them.
    always_ff @(posedge clk_i) begin
        if (wb_v_i) begin
            addr_q[wb_sb_num_i] <= wb_addr_i;
            data_q[wb_sb_num_i] <= wb_data_i;
        end
    end

    logic [PW-1:0] wb_rel;
    assign wb_rel = wb_sb_num_i - head;

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            if (wb_v_i) begin
                assert ({1'b0, wb_rel} < count);
            end
            if (rob_st_retire_i) begin
                assert (wb[ret] && (ret_count < count));
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench for store_buffer with a queue-based reference model
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_v;
    logic [2:0]  alloc_sb_num;
    logic        sb_full;
    logic        sb_empty;
    logic        wb_v;
    logic [2:0]  wb_sb_num;
    logic [15:0] wb_addr;
    logic [15:0] wb_data;
    logic        retire;
    logic        flush;
    logic [7:0]  wb_vector;
    logic [2:0]  commit_pt;
    logic        mem_v;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .alloc_v_i       (alloc_v),
        .alloc_sb_num_o  (alloc_sb_num),
        .sb_full_o       (sb_full),
        .sb_empty_o      (sb_empty),
        .wb_v_i          (wb_v),
        .wb_sb_num_i     (wb_sb_num),
        .wb_addr_i       (wb_addr),
        .wb_data_i       (wb_data),
        .rob_st_retire_i (retire),
        .flush_i         (flush),
        .sb_wb_vector_o  (wb_vector),
        .sb_commit_pt_o  (commit_pt),
        .mem_v_o         (mem_v),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data),
        .mem_ready_i     (mem_ready)
    );

    // Reference model: the live window as an ordered queue of stores.
    typedef struct {
        int          idx;
        bit          w;
        bit          r;
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t q[$];
    int   mhead  = 0;
    bit   chk_en = 0;
    int   m_nret;
    bit   m_drain;
    bit   m_full;
    ent_t m_e;

    always @(posedge clk) begin
        if (!reset_n) begin
            q.delete();
            mhead  = 0;
            chk_en = 1;
        end else begin
            m_nret = 0;
            foreach (q[k]) if (q[k].r) m_nret++;
            m_drain = (m_nret > 0) && mem_ready;
            m_full  = (q.size() == 8);
            if (wb_v) begin
                foreach (q[k]) begin
                    if (q[k].idx == int'(wb_sb_num)) begin
                        q[k].w = 1;
                        q[k].a = wb_addr;
                        q[k].d = wb_data;
                    end
                end
            end
            if (retire) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (!q[k].r) begin
                        q[k].r = 1;
                        break;
                    end
                end
            end
            if (m_drain) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % 8;
            end
            if (flush) begin
                while (q.size() > 0 && !q[q.size()-1].r) void'(q.pop_back());
            end
            if (alloc_v && !m_full && !flush) begin
                m_e.idx = (mhead + q.size()) % 8;
                m_e.w   = 0;
                m_e.r   = 0;
                m_e.a   = '0;
                m_e.d   = '0;
                q.push_back(m_e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [7:0] c_vec;
    int         c_nret;

    always @(negedge clk) begin
        if (chk_en) begin
            c_vec  = '0;
            c_nret = 0;
            foreach (q[k]) begin
                if (q[k].w) c_vec[q[k].idx] = 1'b1;
                if (q[k].r) c_nret++;
            end
            chk("m_full",      32'(sb_full),      32'(q.size() == 8));
            chk("m_empty",     32'(sb_empty),     32'(q.size() == 0));
            chk("m_alloc_num", 32'(alloc_sb_num), 32'((mhead + q.size()) % 8));
            chk("m_commit_pt", 32'(commit_pt),    32'(mhead));
            chk("m_wb_vector", 32'(wb_vector),    32'(c_vec));
            chk("m_mem_v",     32'(mem_v),        32'(c_nret > 0));
            if (c_nret > 0) begin
                chk("m_mem_addr", 32'(mem_addr), 32'(q[0].a));
                chk("m_mem_data", 32'(mem_data), 32'(q[0].d));
            end
        end
    end

    task automatic set_in(input logic a, input logic w, input int wn, input logic [15:0] ad,
                          input logic [15:0] da, input logic r, input logic f, input logic rdy);
        alloc_v   = a;
        wb_v      = w;
        wb_sb_num = 3'(wn);
        wb_addr   = ad;
        wb_data   = da;
        retire    = r;
        flush     = f;
        mem_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic a, input logic w, input int wn, input logic [15:0] ad,
                         input logic [15:0] da, input logic r, input logic f, input logic rdy);
        set_in(a, w, wn, ad, da, r, f, rdy);
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"},  32'(sb_empty),     32'd1);
        chk({tag, "_full"},   32'(sb_full),      32'd0);
        chk({tag, "_mem_v"},  32'(mem_v),        32'd0);
        chk({tag, "_vec"},    32'(wb_vector),    32'd0);
        chk({tag, "_commit"}, 32'(commit_pt),    32'd0);
        chk({tag, "_alloc"},  32'(alloc_sb_num), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, fill, wrap
        do_reset();
        step();
        chk_reset_vals("rst");
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("fill_alloc_num", 32'(alloc_sb_num), 32'(i));
            step();
        end
        chk("fill_full", 32'(sb_full), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("ninth_tail", 32'(alloc_sb_num), 32'd0);
        chk("ninth_full", 32'(sb_full), 32'd1);

        // Writeback vector
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 2, 16'h0012, 16'h00A2, 0, 0, 0);
        drive(0, 1, 0, 16'h0010, 16'h00A0, 0, 0, 0);
        chk("wbvec_vector", 32'(wb_vector), 32'h05);
        chk("wbvec_commit", 32'(commit_pt), 32'd0);

        // Retire and drain
        for (int i = 0; i < 4; i++) drive(0, 1, i, 16'(16'h10 + i), 16'(16'hA0 + i), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("rd_mem_v", 32'(mem_v), 32'd1);
        chk("rd_addr0", 32'(mem_addr), 32'h10);
        chk("rd_data0", 32'(mem_data), 32'hA0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rd_commit1", 32'(commit_pt), 32'd1);
        chk("rd_addr1", 32'(mem_addr), 32'h11);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rd_commit2", 32'(commit_pt), 32'd2);
        chk("rd_mem_v_lo", 32'(mem_v), 32'd0);
        chk("rd_vector", 32'(wb_vector), 32'h0C);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Flush
        do_reset();
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, i, 16'(16'h50 + i), 16'(16'hC0 + i), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        chk("fl_tail", 32'(alloc_sb_num), 32'd2);
        chk("fl_vector", 32'(wb_vector), 32'h03);
        chk("fl_full", 32'(sb_full), 32'd0);
        chk("fl_mem_v", 32'(mem_v), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("fl_empty", 32'(sb_empty), 32'd1);
        chk("fl_commit", 32'(commit_pt), 32'd2);

        // Wrap with simultaneous events: first move head to 6
        do_reset();
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 1, i, 16'h0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("wr_head6", 32'(commit_pt), 32'd6);
        chk("wr_empty", 32'(sb_empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("wr_alloc_num", 32'(alloc_sb_num), 32'((6 + i) % 8));
            step();
        end
        chk("wr_full", 32'(sb_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, (6 + i) % 8, 16'(16'h60 + (6 + i) % 8), 16'(16'hB0 + (6 + i) % 8), 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("wr_refused_tail", 32'(alloc_sb_num), 32'd6);
        chk("wr_refused_full", 32'(sb_full), 32'd0);
        chk("wr_commit7", 32'(commit_pt), 32'd7);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("wr_addr7", 32'(mem_addr), 32'h67);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        chk("wr_rd_mem_v", 32'(mem_v), 32'd1);
        chk("wr_rd_commit", 32'(commit_pt), 32'd0);
        chk("wr_rd_addr0", 32'(mem_addr), 32'h60);
        drive(1, 1, 3, 16'h0AAA, 16'h0BBB, 0, 1, 0);
        chk("wr_fl_tail", 32'(alloc_sb_num), 32'd1);
        chk("wr_fl_vector", 32'(wb_vector), 32'h01);
        chk("wr_fl_mem_v", 32'(mem_v), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("wr_end_empty", 32'(sb_empty), 32'd1);
        chk("wr_end_commit", 32'(commit_pt), 32'd1);

        // Mid-operation reset
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, i, 16'(16'h30 + i), 16'(16'hD0 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("mr_mem_v", 32'(mem_v), 32'd1);
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        reset_n = 1'b1;
        chk_reset_vals("mr");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            chk("mr_no_mem_v", 32'(mem_v), 32'd0);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
